// File: rtl/stream_checker.sv
// stream_checker: drives a fixed serial stimulus frame into a DUT over a
// valid/ready link and checks the DUT's serial output against a fixed
// expected frame. It counts mismatches and reports done/pass.
// Optional feature: define STREAM_CHECKER_FIRSTERR_EN to capture the bit
// index of the first mismatch in first_err_idx. Otherwise that port is tied to 0.
module stream_checker #(
  parameter int unsigned        VEC_LEN    = 96,
  parameter logic [VEC_LEN-1:0] STIM_VEC   = 96'hACBCD2114DAE1577C6DBF4C9,
  parameter logic [VEC_LEN-1:0] EXP_VEC    = 96'h558AC4A53A1724E163AC2BF9,
  parameter int unsigned        NUM_FRAMES = 1,
  parameter int unsigned        ERR_W      = 8,
  localparam int unsigned       IDX_W      = $clog2(VEC_LEN)
) (
  input  logic             clk,
  input  logic             reset_N,
  input  logic             start,
  output logic             stim_data,
  output logic             stim_valid,
  input  logic             stim_ready,
  input  logic             dut_data,
  input  logic             dut_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] first_err_idx
);

  localparam int unsigned FRM_W = $clog2(NUM_FRAMES + 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(VEC_LEN - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] stim_idx_q, stim_idx_d;
  logic [IDX_W-1:0] chk_idx_q, chk_idx_d;
  logic [FRM_W-1:0] stim_frm_q, stim_frm_d;
  logic [FRM_W-1:0] chk_frm_q, chk_frm_d;
  logic             stim_valid_q, stim_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic stim_fire;
  logic chk_fire;
  logic mismatch;
  logic run_start;

  // Handshake qualifiers. A start request is honoured only outside RUN.
  always_comb begin
    stim_fire = stim_valid_q && stim_ready;
    chk_fire  = (state_q == RUN) && dut_valid;
    mismatch  = chk_fire && (dut_data != EXP_VEC[chk_idx_q]);
    run_start = start && (state_q != RUN);
  end

  // Next-state logic. The stimulus and check sides advance independently.
  always_comb begin
    state_d      = state_q;
    stim_idx_d   = stim_idx_q;
    chk_idx_d    = chk_idx_q;
    stim_frm_d   = stim_frm_q;
    chk_frm_d    = chk_frm_q;
    stim_valid_d = stim_valid_q;
    err_d        = err_q;

    if (run_start) begin
      state_d      = RUN;
      stim_idx_d   = IDX_TOP;
      chk_idx_d    = IDX_TOP;
      stim_frm_d   = '0;
      chk_frm_d    = '0;
      stim_valid_d = 1'b1;
      err_d        = '0;
    end else if (state_q == RUN) begin
      if (stim_fire) begin
        if (stim_idx_q == '0) begin
          stim_idx_d = IDX_TOP;
          stim_frm_d = stim_frm_q + FRM_W'(1);
          if (stim_frm_q == FRM_LAST) begin
            stim_valid_d = 1'b0;
          end
        end else begin
          stim_idx_d = stim_idx_q - IDX_W'(1);
        end
      end

      if (chk_fire) begin
        if (mismatch && (err_q != '1)) begin
          err_d = err_q + ERR_W'(1);
        end
        if (chk_idx_q == '0) begin
          chk_idx_d = IDX_TOP;
          chk_frm_d = chk_frm_q + FRM_W'(1);
          if (chk_frm_q == FRM_LAST) begin
            state_d      = DONE;
            stim_valid_d = 1'b0;
          end
        end else begin
          chk_idx_d = chk_idx_q - IDX_W'(1);
        end
      end
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (err_d == '0);
  end

  // State and registered outputs. Reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!reset_N) begin
      state_q      <= IDLE;
      stim_idx_q   <= IDX_TOP;
      chk_idx_q    <= IDX_TOP;
      stim_frm_q   <= '0;
      chk_frm_q    <= '0;
      stim_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      stim_idx_q   <= stim_idx_d;
      chk_idx_q    <= chk_idx_d;
      stim_frm_q   <= stim_frm_d;
      chk_frm_q    <= chk_frm_d;
      stim_valid_q <= stim_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
    end
  end

`ifdef STREAM_CHECKER_FIRSTERR_EN
  logic [IDX_W-1:0] first_err_q, first_err_d;

  // A zero error count means no mismatch has been seen yet in this run.
  // The count saturates and never wraps back to zero.
  always_comb begin
    first_err_d = first_err_q;
    if (run_start) begin
      first_err_d = '0;
    end else if (mismatch && (err_q == '0)) begin
      first_err_d = chk_idx_q;
    end
  end

  // First-mismatch index register.
  always_ff @(posedge clk) begin
    if (!reset_N) begin
      first_err_q <= '0;
    end else begin
      first_err_q <= first_err_d;
    end
  end

  assign first_err_idx = first_err_q;
`else
  assign first_err_idx = '0;
`endif

  assign stim_data  = STIM_VEC[stim_idx_q];
  assign stim_valid = stim_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_stream_checker.sv
// tb_stream_checker: scoreboard bench for stream_checker. Two instances are
// used. Instance 0 uses the default parameters. Instance 1 uses
// NUM_FRAMES=3 and ERR_W=4. A behavioural responder stands in for the
// device under test.
module tb_stream_checker;

  localparam int unsigned VL     = 96;
  localparam int unsigned BUDGET = 2000;

  typedef struct {
    logic [7:0]  err;
    logic        pass;
    logic [6:0]  ferr;
    int unsigned xfers;
  } res_t;

  logic       clk = 1'b0;
  logic       reset_N = 1'b0;
  logic       start_v      [2];
  logic       stim_ready_v [2];
  logic       dut_data_v   [2];
  logic       dut_valid_v  [2];
  logic       stim_data_o  [2];
  logic       stim_valid_o [2];
  logic       busy_o       [2];
  logic       done_o       [2];
  logic       pass_o       [2];
  logic [6:0] ferr_o       [2];
  logic [7:0] err_o        [2];
  logic [7:0] err_a;
  logic [3:0] err_b;

  logic [95:0] stim_ref;
  logic [95:0] key_ref;

  // Responder state
  int          sel;
  int          mode;        // 0 known-good, 1 loopback, 2 inverted
  bit          model_en;
  bit          toggle_rdy;
  int unsigned m_idx, m_xfers, m_sent, m_total;
  logic        rsp_q [$];
  bit          hold_chk, last_pending;
  logic        hold_val;
  logic        man_valid, man_data;

  res_t exp_q [$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  stream_checker u_dut_a (
    .clk          (clk),
    .reset_N      (reset_N),
    .start        (start_v[0]),
    .stim_data    (stim_data_o[0]),
    .stim_valid   (stim_valid_o[0]),
    .stim_ready   (stim_ready_v[0]),
    .dut_data     (dut_data_v[0]),
    .dut_valid    (dut_valid_v[0]),
    .busy         (busy_o[0]),
    .done         (done_o[0]),
    .pass         (pass_o[0]),
    .err_count    (err_a),
    .first_err_idx(ferr_o[0])
  );

  stream_checker #(.NUM_FRAMES(3), .ERR_W(4)) u_dut_b (
    .clk          (clk),
    .reset_N      (reset_N),
    .start        (start_v[1]),
    .stim_data    (stim_data_o[1]),
    .stim_valid   (stim_valid_o[1]),
    .stim_ready   (stim_ready_v[1]),
    .dut_data     (dut_data_v[1]),
    .dut_valid    (dut_valid_v[1]),
    .busy         (busy_o[1]),
    .done         (done_o[1]),
    .pass         (pass_o[1]),
    .err_count    (err_b),
    .first_err_idx(ferr_o[1])
  );

  assign err_o[0] = err_a;
  assign err_o[1] = {4'b0000, err_b};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One responder step, taken on the falling edge. It sets the inputs for the
  // next rising edge and records the transfer that edge will perform.
  task automatic model_step();
    logic rdy, sbit, rsp;
    if (!model_en) begin
      stim_ready_v[sel] = 1'b0;
      dut_valid_v[sel]  = man_valid;
      dut_data_v[sel]   = man_data;
      hold_chk          = 0;
      last_pending      = 0;
    end else begin
      if (last_pending) begin
        check_eq("done_after_last", done_o[sel], 1'b1);
        last_pending = 0;
      end
      if (hold_chk) begin
        check_eq("stall_hold", stim_data_o[sel], hold_val);
        hold_chk = 0;
      end
      if (rsp_q.size() > 0) begin
        dut_valid_v[sel] = 1'b1;
        dut_data_v[sel]  = rsp_q.pop_front();
        m_sent++;
        if (m_sent == m_total) begin
          check_eq("done_before_last", done_o[sel], 1'b0);
          last_pending = 1;
        end
      end else begin
        dut_valid_v[sel] = 1'b0;
        dut_data_v[sel]  = 1'b0;
      end
      rdy = toggle_rdy ? ~stim_ready_v[sel] : 1'b1;
      stim_ready_v[sel] = rdy;
      if (reset_N && stim_valid_o[sel] && rdy) begin
        sbit = stim_data_o[sel];
        check_eq("stim_bit", sbit, stim_ref[m_idx]);
        case (mode)
          1:       rsp = sbit;
          2:       rsp = ~(sbit ^ key_ref[m_idx]);
          default: rsp = sbit ^ key_ref[m_idx];
        endcase
        rsp_q.push_back(rsp);
        m_idx = (m_idx == 0) ? VL - 1 : m_idx - 1;
        m_xfers++;
      end else if (reset_N && stim_valid_o[sel] && !rdy) begin
        hold_chk = 1;
        hold_val = stim_data_o[sel];
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int s, input int md, input bit tog, input int unsigned frames,
                     input int unsigned sat);
    res_t        e;
    int unsigned errs, first, idx;
    bit          found, mis;
    errs  = 0;
    first = 0;
    found = 0;
    for (int unsigned i = 0; i < frames * VL; i++) begin
      idx = VL - 1 - (i % VL);
      mis = (md == 1) ? key_ref[idx] : (md == 2);
      if (mis) begin
        errs++;
        if (!found) begin
          first = idx;
          found = 1;
        end
      end
    end
    e.err  = 8'((errs > sat) ? sat : errs);
    e.pass = (errs == 0);
`ifdef STREAM_CHECKER_FIRSTERR_EN
    e.ferr = 7'(first);
`else
    e.ferr = 7'd0;
`endif
    e.xfers = frames * VL;
    exp_q.push_back(e);
    sel          = s;
    mode         = md;
    toggle_rdy   = tog;
    m_idx        = VL - 1;
    m_xfers      = 0;
    m_sent       = 0;
    m_total      = frames * VL;
    hold_chk     = 0;
    last_pending = 0;
    rsp_q.delete();
    model_en     = 1;
    start_v[s]   = 1'b1;
    tick();
    start_v[s]   = 1'b0;
    check_eq("busy_on_start", busy_o[s], 1'b1);
    check_eq("done_falls", done_o[s], 1'b0);
    check_eq("pass_falls", pass_o[s], 1'b0);
  endtask

  task automatic wait_done(input int s, output res_t e);
    int c;
    c = 0;
    while (!done_o[s] && c < BUDGET) begin
      tick();
      c++;
    end
    check_eq("done_timeout", done_o[s], 1'b1);
    e = exp_q.pop_front();
    check_eq("err_count", err_o[s], e.err);
    check_eq("pass", pass_o[s], e.pass);
    check_eq("first_err_idx", ferr_o[s], e.ferr);
    check_eq("transfers", m_xfers, e.xfers);
    check_eq("busy_off", busy_o[s], 1'b0);
    check_eq("stim_valid_off", stim_valid_o[s], 1'b0);
    tick();
    model_en = 0;
  endtask

  task automatic check_reset_state(input int s);
    check_eq("rst_busy", busy_o[s], 1'b0);
    check_eq("rst_done", done_o[s], 1'b0);
    check_eq("rst_pass", pass_o[s], 1'b0);
    check_eq("rst_err", err_o[s], 8'd0);
    check_eq("rst_ferr", ferr_o[s], 7'd0);
    check_eq("rst_stim_valid", stim_valid_o[s], 1'b0);
  endtask

  initial begin
    res_t e;
    int   c;
    stim_ref  = 96'hACBCD2114DAE1577C6DBF4C9;
    key_ref   = stim_ref ^ 96'h558AC4A53A1724E163AC2BF9;
    for (int i = 0; i < 2; i++) begin
      start_v[i]      = 1'b0;
      stim_ready_v[i] = 1'b0;
      dut_data_v[i]   = 1'b0;
      dut_valid_v[i]  = 1'b0;
    end
    sel       = 0;
    mode      = 0;
    model_en  = 0;
    man_valid = 1'b0;
    man_data  = 1'b0;

    repeat (3) tick();
    check_reset_state(0);
    check_reset_state(1);
    reset_N = 1'b1;
    tick();

    // Known-good responder, defaults
    run(0, 0, 0, 1, 255);
    wait_done(0, e);

    // Loopback: every bit where stimulus and expected differ is an error
    run(0, 1, 0, 1, 255);
    wait_done(0, e);

    // Three frames with ready toggling
    run(1, 0, 1, 3, 15);
    wait_done(1, e);

    // Inverted responder saturates the 4-bit counter
    run(1, 2, 0, 3, 15);
    wait_done(1, e);

    // Reset in the middle of a run
    run(0, 0, 0, 1, 255);
    c = 0;
    while (m_xfers < 40 && c < BUDGET) begin
      tick();
      c++;
    end
    check_eq("reach_bit40", (m_xfers >= 40), 1'b1);
    reset_N = 1'b0;
    tick();
    reset_N = 1'b1;
    void'(exp_q.pop_back());
    model_en = 0;
    rsp_q.delete();
    check_reset_state(0);
    repeat (3) tick();
    check_eq("no_self_restart", busy_o[0], 1'b0);
    run(0, 0, 0, 1, 255);
    wait_done(0, e);

    // Start during RUN is ignored; dut_valid in DONE is ignored
    run(0, 1, 0, 1, 255);
    repeat (10) tick();
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    check_eq("start_in_run_busy", busy_o[0], 1'b1);
    wait_done(0, e);
    man_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      man_data = ~man_data;
      tick();
    end
    man_valid = 1'b0;
    tick();
    check_eq("done_hold_err", err_o[0], e.err);
    check_eq("done_hold_done", done_o[0], 1'b1);
    check_eq("done_hold_pass", pass_o[0], e.pass);

    // Restart from DONE
    run(0, 0, 0, 1, 255);
    wait_done(0, e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
